stopwatch_ctrl: RTL and testbench

- Stopwatch sequencer that feeds the 4-digit multiplexed display in M:SS.t format.
- Holds a 100 ms prescaler and a 4-digit BCD time counter. Runs a run/pause/lap/clear FSM from single-cycle button pulses.
- Drives the display mux's hex3..hex0 inputs with either the live time or a frozen lap value.
- Button pulses arrive already debounced and edge-detected upstream.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 45 ++++
 rtl/stopwatch_ctrl.sv | 134 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared state encoding and BCD digit limits for the
//                stopwatch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [3:0] TENTHS_MAX   = 4'd9;
    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_MAX      = 4'd9;

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : Single BCD digit counting 0..MAX with synchronous clear and
//                a combinational carry raised on the increment that wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    // Next digit value: clear wins over increment, wrap to 0 past MAX.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (inc) begin
            value_d = (value_q == MAX) ? 4'd0 : value_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Run/pause/lap/clear stopwatch with a 0.1 s prescaler and a
//                four-digit BCD M:SS.t counter feeding the display mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 10_000_000,
    parameter int PRESCALE_W = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic       running,
    output logic       frozen,
    output logic       wrap_pulse
);

    localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [15:0]           lap_q,   lap_d;
    logic                  wrap_q;

    logic                  counting;
    logic                  tick;
    logic                  lap_capture;
    logic                  clr_time;
    logic [3:0]            d_tenths, d_sec_ones, d_sec_tens, d_min;
    logic                  c_tenths, c_sec_ones, c_sec_tens, c_min;
    logic [15:0]           time_vec;

    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick     = counting && (presc_q == TICK_LAST);
    assign time_vec = {d_min, d_sec_tens, d_sec_ones, d_tenths};

    // Next-state logic; clear > start_stop > lap, only pulses valid in the
    // current state take part in the priority.
    always_comb begin
        state_d     = state_q;
        lap_capture = 1'b0;
        clr_time    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                if (start_stop) begin
                    state_d = PAUSE;
                end else if (lap) begin
                    state_d     = LAP;
                    lap_capture = 1'b1;
                end
            end
            LAP: begin
                if (start_stop) state_d = PAUSE;
                else if (lap)   state_d = RUN;
            end
            PAUSE: begin
                if (clear) begin
                    state_d  = IDLE;
                    clr_time = 1'b1;
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler and lap register next values; the lap snapshot is taken from
    // the digit registers so a coincident tick is not yet reflected.
    always_comb begin
        presc_d = presc_q;
        if (state_q == IDLE || clr_time) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
        end
        lap_d = lap_capture ? time_vec : lap_q;
    end

    // State, prescaler, lap and wrap registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            lap_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            lap_q   <= lap_d;
            wrap_q  <= c_min;
        end
    end

    bcd_digit #(.MAX(TENTHS_MAX)) u_tenths (
        .clock (clock), .reset (reset), .inc (tick),       .clr (clr_time),
        .value (d_tenths),   .carry (c_tenths)
    );

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clock (clock), .reset (reset), .inc (c_tenths),   .clr (clr_time),
        .value (d_sec_ones), .carry (c_sec_ones)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clock (clock), .reset (reset), .inc (c_sec_ones), .clr (clr_time),
        .value (d_sec_tens), .carry (c_sec_tens)
    );

    bcd_digit #(.MAX(MIN_MAX)) u_min (
        .clock (clock), .reset (reset), .inc (c_sec_tens), .clr (clr_time),
        .value (d_min),      .carry (c_min)
    );

    assign running    = counting;
    assign frozen     = (state_q == LAP);
    assign wrap_pulse = wrap_q;
    assign {hex3, hex2, hex1, hex0} = frozen ? lap_q : time_vec;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Directed bench for stopwatch_ctrl with TICK_DIV = 4.
//                k below is the number of counting edges since start, so the
//                live display equals k/4 tenths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stop, lap, clear;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic        running, frozen, wrap_pulse;
    logic [15:0] disp;

    int n_asserts = 0;
    int n_fail    = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .PRESCALE_W(3)) dut (
        .clock      (clk),
        .reset      (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .hex3       (hex3),
        .hex2       (hex2),
        .hex1       (hex1),
        .hex0       (hex0),
        .running    (running),
        .frozen     (frozen),
        .wrap_pulse (wrap_pulse)
    );

    assign disp = {hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        step(1);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        step(2);
        chk("reset_disp",    disp,               16'h0000);
        chk("reset_running", {15'd0, running},   16'd0);
        chk("reset_frozen",  {15'd0, frozen},    16'd0);
        chk("reset_wrap",    {15'd0, wrap_pulse},16'd0);
        rst = 1'b0;
        step(1);

        // start; k=0
        pulse(1, 0, 0);
        chk("start_running", {15'd0, running}, 16'd1);
        chk("start_frozen",  {15'd0, frozen},  16'd0);
        step(3);                                   // k=3
        chk("tick_not_yet",  disp, 16'h0000);
        step(1);                                   // k=4
        chk("first_tick",    disp, 16'h0001);
        step(36);                                  // k=40
        chk("count_1s",      disp, 16'h0010);

        // lap at 0:02.3
        step(52);                                  // k=92
        chk("pre_lap",       disp, 16'h0023);
        pulse(0, 1, 0);                            // k=93
        chk("lap_hold",      disp, 16'h0023);
        chk("lap_frozen",    {15'd0, frozen},  16'd1);
        chk("lap_running",   {15'd0, running}, 16'd1);
        step(4);                                   // k=97, internal 0:02.4
        chk("lap_still",     disp, 16'h0023);
        step(43);                                  // k=140, internal 0:03.5
        pulse(0, 1, 0);                            // k=141
        chk("lap_release",   disp, 16'h0035);
        chk("release_frozen",{15'd0, frozen}, 16'd0);

        // lap coincident with tick: prescaler at 3 when k=143
        step(2);                                   // k=143
        pulse(0, 1, 0);                            // k=144, time 0:03.6
        chk("lap_on_tick",   disp, 16'h0035);
        pulse(0, 1, 0);                            // k=145
        chk("lap_on_tick_live", disp, 16'h0036);

        // pause with prescaler at 2, lap in PAUSE ignored
        step(1);                                   // k=146, presc=2
        pulse(1, 0, 0);                            // presc=3 held
        chk("pause_running", {15'd0, running}, 16'd0);
        chk("pause_disp",    disp, 16'h0036);
        step(5);
        chk("pause_hold",    disp, 16'h0036);
        pulse(0, 1, 0);
        chk("pause_lap_ign", {15'd0, frozen},  16'd0);
        chk("pause_lap_run", {15'd0, running}, 16'd0);
        pulse(1, 0, 0);                            // resume, presc=3
        chk("resume_running",{15'd0, running}, 16'd1);
        chk("resume_no_tick",disp, 16'h0036);
        step(1);                                   // k=148
        chk("resume_tick",   disp, 16'h0037);

        // clear in RUN ignored
        pulse(0, 0, 1);                            // k=149
        chk("run_clear_ign", disp, 16'h0037);
        chk("run_clear_run", {15'd0, running}, 16'd1);

        // seconds-to-minutes carry
        step(2250);                                // k=2399
        chk("pre_min_carry", disp, 16'h0599);
        step(1);                                   // k=2400
        chk("min_carry",     disp, 16'h1000);

        // wrap at 9:59.9
        step(21599);                               // k=23999
        chk("pre_wrap",      disp, 16'h9599);
        chk("pre_wrap_pulse",{15'd0, wrap_pulse}, 16'd0);
        step(1);                                   // k=24000
        chk("wrap_disp",     disp, 16'h0000);
        chk("wrap_pulse",    {15'd0, wrap_pulse}, 16'd1);
        chk("wrap_running",  {15'd0, running},    16'd1);
        step(1);                                   // k=24001
        chk("wrap_one_cycle",{15'd0, wrap_pulse}, 16'd0);

        // clear + start_stop in PAUSE -> IDLE
        step(7);                                   // k=24008
        pulse(1, 0, 0);
        chk("pause2_disp",   disp, 16'h0002);
        pulse(1, 0, 1);
        chk("clear_disp",    disp, 16'h0000);
        chk("clear_running", {15'd0, running}, 16'd0);
        pulse(0, 1, 0);
        chk("idle_lap_ign",  {15'd0, frozen},  16'd0);
        step(3);
        chk("idle_hold",     disp, 16'h0000);

        // restart from a zeroed prescaler
        pulse(1, 0, 0);
        step(3);
        chk("restart_no_tick", disp, 16'h0000);
        step(1);
        chk("restart_tick",  disp, 16'h0001);

        // asynchronous reset mid-run
        step(5);
        rst = 1'b1;
        #1;
        chk("async_rst_disp",    disp, 16'h0000);
        chk("async_rst_running", {15'd0, running}, 16'd0);
        step(1);
        rst = 1'b0;
        step(6);
        chk("post_rst_idle",     disp, 16'h0000);
        chk("post_rst_running",  {15'd0, running}, 16'd0);
        pulse(1, 0, 0);
        chk("post_rst_start",    {15'd0, running}, 16'd1);
        step(3);
        chk("post_rst_no_tick",  disp, 16'h0000);
        step(1);
        chk("post_rst_tick",     disp, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
